// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage front end for the iterative 32-bit divider.
// Accepts DIV/DIVU, holds operands for the whole operation, stalls the pipe
// while the divide is in flight, and issues a one-cycle HI/LO write.
// Also has a watchdog abort and a saturating busy-cycle counter.
//
// Handshake: a request is accepted in IDLE when div_req_i=1 and flush_i=0.
// div_start_o stays high for the whole operation. The operation ends when
// div_ready_i=1 (result), flush_i=1 (annul) or the watchdog expires (annul).
// Flush wins over ready. Ready wins over a watchdog expiry in the same cycle.
module div_issue_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_req_i,
  input  logic             signed_i,
  input  logic [31:0]      opdata1_i,
  input  logic [31:0]      opdata2_i,
  input  logic             flush_i,
  input  logic             div_ready_i,
  input  logic [63:0]      div_result_i,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_signed_o,
  output logic [31:0]      div_opdata1_o,
  output logic [31:0]      div_opdata2_o,
  output logic             stallreq_o,
  output logic             whilo_o,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] busy_cycles_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q;
  logic            accept;
  logic            done;
  logic            wd_abort;
  logic            wd_expired;

  // The watchdog fires in the TIMEOUT-th cycle spent in BUSY.
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  // Next state, stall, annul and the accept/done/abort strobes.
  always_comb begin
    state_d     = state_q;
    stallreq_o  = 1'b0;
    div_annul_o = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    wd_abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_req_i && !flush_i) begin
          accept     = 1'b1;
          stallreq_o = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = S_IDLE;
        end else if (div_ready_i) begin
          done    = 1'b1;
          state_d = S_DRAIN;
        end else if (wd_expired) begin
          wd_abort    = 1'b1;
          div_annul_o = 1'b1;
          state_d     = S_IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      S_DRAIN: begin
        // A divide presented here waits until IDLE so start drops for a cycle.
        stallreq_o = div_req_i;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write strobe is the single DRAIN cycle.
  assign whilo_o = (state_q == S_DRAIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Start flag and operand capture; operands stay frozen until the next accept
  // because the divider re-reads the operand signs at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_start_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
    end else if (accept) begin
      div_start_o   <= 1'b1;
      div_signed_o  <= signed_i;
      div_opdata1_o <= opdata1_i;
      div_opdata2_o <= opdata2_i;
    end else if (state_q == S_BUSY && state_d != S_BUSY) begin
      div_start_o <= 1'b0;
    end
  end

  // Result capture on normal completion only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (done) begin
      hi_o <= div_result_i[63:32];
      lo_o <= div_result_i[31:0];
    end
  end

  // Watchdog counter and the one-cycle timeout pulse after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= wd_abort;
      if (accept)                 wd_q <= '0;
      else if (state_q == S_BUSY) wd_q <= wd_q + WD_W'(1);
    end
  end

  // Saturating count of every cycle spent in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cycles_o <= '0;
    end else if (state_q == S_BUSY && busy_cycles_o != {CNT_W{1'b1}}) begin
      busy_cycles_o <= busy_cycles_o + CNT_W'(1);
    end
  end

endmodule
